// File: rtl/ram_loader.sv
// ram_loader: boot loader in front of the RAM write port.
// Passes CPU writes through when idle. When loading, packs a byte stream (high byte first) into words at consecutive addresses.
module ram_loader #(
  parameter int ADDR_WIDTH = 12,
  parameter int BASE_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [12:0]           length,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  input  logic [15:0]           cpu_in,
  input  logic [ADDR_WIDTH-1:0] cpu_address,
  input  logic                  cpu_load,
  output logic [15:0]           ram_in,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_load,
  output logic                  busy,
  output logic                  done,
  output logic [12:0]           words_written
);
  localparam logic [2:0] S_IDLE = 3'd0, S_HI = 3'd1, S_LO = 3'd2, S_WRITE = 3'd3, S_DONE = 3'd4;
  logic [2:0] r_state;
  logic [12:0] r_len, r_words;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0] r_hi, r_lo;
  logic w_idle;
  logic [12:0] w_len_sat;
  assign w_idle = r_state == S_IDLE;
  assign w_len_sat = (length > 13'd4096) ? 13'd4096 : length;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_words <= '0;
      r_addr <= ADDR_WIDTH'(BASE_ADDR);
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_state <= (length == 13'd0) ? S_DONE : S_HI;
          r_len <= w_len_sat;
          r_addr <= ADDR_WIDTH'(BASE_ADDR);
          r_words <= '0;
        end
        S_HI: if (byte_valid) begin
          r_hi <= byte_in;
          r_state <= S_LO;
        end
        S_LO: if (byte_valid) begin
          r_lo <= byte_in;
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          r_words <= r_words + 13'd1;
          r_addr <= r_addr + ADDR_WIDTH'(1);
          r_state <= (r_words + 13'd1 == r_len) ? S_DONE : S_HI;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign byte_ready = (r_state == S_HI) || (r_state == S_LO);
  assign busy = byte_ready || (r_state == S_WRITE);
  assign done = r_state == S_DONE;
  assign words_written = r_words;
  assign ram_load = !reset && (w_idle ? cpu_load : r_state == S_WRITE);
  assign ram_address = w_idle ? cpu_address : r_addr;
  assign ram_in = w_idle ? cpu_in : {r_hi, r_lo};
endmodule

// File: doc/ram_loader.md
Name: ram_loader

Overview:
- Upstream write-port front end for the 4K x 16 RAM.
- When idle, it passes CPU write/address traffic straight through to the RAM.
- When started, it takes over the RAM write port, assembles a byte stream (high byte first) into 16-bit words, and writes them to consecutive addresses.
- Used to boot-load program/data images into RAM from a byte source such as a UART receiver.

Parameters:
- ADDR_WIDTH, 12, RAM address width (4096 words).
- BASE_ADDR, 0, first RAM address written by a load; must fit in ADDR_WIDTH.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a load; sampled only in IDLE.
- length  input  13  number of words to load; sampled with start; values >4096 saturate to 4096.
- byte_in  input  8  stream data byte.
- byte_valid  input  1  byte_in valid.
- byte_ready  output  1  loader accepts byte_in this cycle.
- cpu_in  input  16  CPU write data.
- cpu_address  input  12  CPU address.
- cpu_load  input  1  CPU write enable.
- ram_in  output  16  to the RAM in port.
- ram_address  output  12  to the RAM address port.
- ram_load  output  1  to the RAM load port.
- busy  output  1  load in progress; CPU writes are dropped.
- done  output  1  one-cycle pulse when a load completes.
- words_written  output  13  words written by the current/last load.

Behaviour:
- States: IDLE, HI, LO, WRITE, DONE. Registered state; all datapath registers are clocked by clk.
- Reset: state=IDLE, byte_ready=0, busy=0, done=0, words_written=0, address counter=BASE_ADDR. ram_load is forced to 0 while reset=1.
- IDLE:
  - ram_in=cpu_in, ram_address=cpu_address, ram_load=cpu_load (combinational pass-through, zero latency).
  - byte_ready=0, busy=0.
  - start=1 and length!=0: latch length (saturated), addr=BASE_ADDR, words_written=0; go to HI.
  - start=1 and length==0: go to DONE with no write.
- HI:
  - byte_ready=1, busy=1.
  - On byte_valid&byte_ready: hi_byte<=byte_in, go to LO; otherwise hold.
- LO:
  - byte_ready=1, busy=1.
  - On handshake: lo_byte<=byte_in, go to WRITE.
- WRITE:
  - byte_ready=0, busy=1, ram_load=1, ram_address=addr, ram_in={hi_byte,lo_byte}, all from registers.
  - Next edge: words_written+1, addr+1 (wraps mod 2^ADDR_WIDTH, i.e. 4095->0).
  - If words_written+1==latched length, go to DONE; else go to HI.
- DONE: done=1 for exactly one cycle, busy=0; go to IDLE. words_written holds its final value until the next accepted start.
- While not IDLE: ram_address and ram_in come from the loader; cpu_load is ignored; ram_load=0 except in WRITE.
- Throughput: 3 cycles per word with byte_valid held high. First write occurs in cycle 3 after the start edge. done occurs in the cycle after the last WRITE. N words take 3N+1 cycles from the start edge to done.
- start while busy: ignored, with no effect on length or address.
- byte_valid with byte_ready=0 (IDLE/WRITE/DONE): byte is not consumed; the source must hold it.
- byte_valid deasserted mid-word: the loader stalls in HI/LO indefinitely with no timeout.
- reset mid-load: return to IDLE immediately. Words already written remain in RAM. No done pulse is generated. A partial hi_byte is discarded.

Test Plan:
- Pass-through: IDLE, cpu_address=0x123, cpu_in=0xBEEF, cpu_load=1 -> same-cycle ram_address=0x123, ram_in=0xBEEF, ram_load=1; RAM readback is 0xBEEF.
- Basic load: start, length=3, bytes 12 34 AB CD 00 01 streamed back-to-back -> RAM[0]=0x1234, RAM[1]=0xABCD, RAM[2]=0x0001; done pulses 10 cycles after the start edge; words_written=3.
- Stall and CPU block: drop byte_valid for 5 cycles between hi and lo bytes; toggle cpu_load=1 at address 0 with 0xFFFF -> no extra writes; word still correct; busy=1 throughout.
- Wrap and saturation: BASE_ADDR=4094, length=5000 -> length treated as 4096; writes 4094, 4095, 0, 1, ...; done after 4096 words; words_written=4096.
- Zero length and ignored start: length=0 -> done pulse at cycle 1, no ram_load. A second start during a busy load -> no restart.
- Reset mid-load: reset after 2 of 4 words -> state IDLE, busy=0, no done; RAM[0..1] written, RAM[2..3] unchanged; pass-through resumes the next cycle.
